// File: rtl/key_cfg_ctrl.sv
// Three-key configuration editor. Keys edit a shadow copy of freq/rate/enable.
// The committed values are offered downstream with a valid/ready handshake.
module key_cfg_ctrl #(
  parameter logic [27:0] TIMEOUT  = 28'd200_000_000,
  parameter logic [2:0]  RATE_MAX = 3'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k0,
  input  logic       k1,
  input  logic       k2,
  input  logic       cfg_ready,
  output logic       cfg_valid,
  output logic [3:0] cfg_freq,
  output logic [2:0] cfg_rate,
  output logic       cfg_en,
  output logic       editing,
  output logic [1:0] edit_field
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  field_q, field_d;
  logic [3:0]  sh_freq_q, sh_freq_d;
  logic [2:0]  sh_rate_q, sh_rate_d;
  logic        sh_en_q, sh_en_d;
  logic [3:0]  freq_q, freq_d;
  logic [2:0]  rate_q, rate_d;
  logic        en_q, en_d;
  logic [27:0] cnt_q, cnt_d;

  logic any_key, inc, dec;

  assign any_key = k0 | k1 | k2;
  // Opposing k1/k2 pulses cancel out.
  assign inc     = k1 & ~k2;
  assign dec     = k2 & ~k1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      field_q   <= 2'd0;
      sh_freq_q <= 4'd0;
      sh_rate_q <= 3'd0;
      sh_en_q   <= 1'b0;
      freq_q    <= 4'd0;
      rate_q    <= 3'd0;
      en_q      <= 1'b0;
      cnt_q     <= 28'd0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      sh_freq_q <= sh_freq_d;
      sh_rate_q <= sh_rate_d;
      sh_en_q   <= sh_en_d;
      freq_q    <= freq_d;
      rate_q    <= rate_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    sh_freq_d = sh_freq_q;
    sh_rate_d = sh_rate_q;
    sh_en_d   = sh_en_q;
    freq_d    = freq_q;
    rate_d    = rate_q;
    en_d      = en_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (k0) begin
          state_d   = EDIT;
          field_d   = 2'd0;
          sh_freq_d = freq_q;
          sh_rate_d = rate_q;
          sh_en_d   = en_q;
          cnt_d     = 28'd0;
        end
      end

      EDIT: begin
        // Any key restarts the inactivity window; an abandoned edit drops the shadow.
        if (any_key) begin
          cnt_d = 28'd0;
        end else if (cnt_q == TIMEOUT - 28'd1) begin
          state_d = IDLE;
          cnt_d   = 28'd0;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end

        if (k0) begin
          if (field_q == 2'd2) begin
            state_d = COMMIT;
            freq_d  = sh_freq_q;
            rate_d  = sh_rate_q;
            en_d    = sh_en_q;
          end else begin
            field_d = field_q + 2'd1;
          end
        end else if (inc || dec) begin
          case (field_q)
            2'd0: sh_freq_d = inc ? sh_freq_q + 4'd1 : sh_freq_q - 4'd1;
            2'd1: begin
              if (inc && (sh_rate_q < RATE_MAX)) begin
                sh_rate_d = sh_rate_q + 3'd1;
              end else if (dec && (sh_rate_q != 3'd0)) begin
                sh_rate_d = sh_rate_q - 3'd1;
              end
            end
            default: sh_en_d = ~sh_en_q;
          endcase
        end
      end

      COMMIT: begin
        if (cfg_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state so reset clears cfg_valid without a clock.
  assign cfg_valid  = (state_q == COMMIT);
  assign editing    = (state_q == EDIT);
  assign edit_field = (state_q == EDIT) ? field_q : 2'd0;
  assign cfg_freq   = freq_q;
  assign cfg_rate   = rate_q;
  assign cfg_en     = en_q;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Bench for key_cfg_ctrl: directed key sequences, a per-cycle reference
// model comparison and literal expectations at the end of each scenario.
module tb_key_cfg_ctrl;

  localparam int TO     = 20;
  localparam int RMAX   = 5;
  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_COMMIT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       k0 = 1'b0;
  logic       k1 = 1'b0;
  logic       k2 = 1'b0;
  logic       cfg_ready = 1'b0;
  logic       cfg_valid;
  logic [3:0] cfg_freq;
  logic [2:0] cfg_rate;
  logic       cfg_en;
  logic       editing;
  logic [1:0] edit_field;

  int nChecks = 0;
  int nPass = 0;
  int validCycles = 0;
  int v0;

  // Reference model: mode, field index, shadow and committed values as plain ints.
  int mMode = M_IDLE;
  int mField = 0;
  int mShadow [3] = '{0, 0, 0};
  int mCfg [3] = '{0, 0, 0};
  int edgeNum = 0;
  int lastActivity = 0;

  key_cfg_ctrl #(.TIMEOUT(28'd20)) dut (
    .clk(clk),
    .rst(rst),
    .k0(k0),
    .k1(k1),
    .k2(k2),
    .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid),
    .cfg_freq(cfg_freq),
    .cfg_rate(cfg_rate),
    .cfg_en(cfg_en),
    .editing(editing),
    .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  function automatic int adjust(input int field, input int value, input int step);
    int r;
    r = value + step;
    if (field == 0) return ((r % 16) + 16) % 16;
    if (field == 1) begin
      if (r < 0) r = 0;
      if (r > RMAX) r = RMAX;
      return r;
    end
    return (value == 0) ? 1 : 0;
  endfunction

  // The model tracks the edge of the last activity; an edit is abandoned
  // once TO edges pass without any key.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mMode  <= M_IDLE;
      mField <= 0;
      mCfg   <= '{0, 0, 0};
    end else begin
      edgeNum <= edgeNum + 1;
      if (mMode == M_IDLE) begin
        if (k0) begin
          mMode        <= M_EDIT;
          mField       <= 0;
          mShadow      <= mCfg;
          lastActivity <= edgeNum + 1;
        end
      end else if (mMode == M_EDIT) begin
        if (k0 || k1 || k2) lastActivity <= edgeNum + 1;
        if (k0) begin
          if (mField == 2) begin
            mMode <= M_COMMIT;
            mCfg  <= mShadow;
          end else begin
            mField <= mField + 1;
          end
        end else if (k1 != k2) begin
          mShadow[mField] <= adjust(mField, mShadow[mField], k1 ? 1 : -1);
        end else if (!k1 && (edgeNum + 1 - lastActivity >= TO)) begin
          mMode <= M_IDLE;
        end
      end else begin
        if (cfg_ready) mMode <= M_IDLE;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic c, input logic r);
    k0 = a;
    k1 = b;
    k2 = c;
    cfg_ready = r;
    @(posedge clk);
    #1;
    k0 = 1'b0;
    k1 = 1'b0;
    k2 = 1'b0;
  endtask

  // Every cycle outside reset, all outputs are compared against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("model editing", editing, (mMode == M_EDIT) ? 1 : 0);
      checkOutput("model edit_field", edit_field, (mMode == M_EDIT) ? mField : 0);
      checkOutput("model cfg_valid", cfg_valid, (mMode == M_COMMIT) ? 1 : 0);
      checkOutput("model cfg_freq", cfg_freq, mCfg[0]);
      checkOutput("model cfg_rate", cfg_rate, mCfg[1]);
      checkOutput("model cfg_en", cfg_en, mCfg[2]);
    end
    if (cfg_valid) validCycles++;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset cfg_valid", cfg_valid, 0);
    checkOutput("reset cfg_freq", cfg_freq, 0);
    checkOutput("reset editing", editing, 0);
    checkOutput("reset edit_field", edit_field, 0);

    // Keys other than k0 are ignored while idle.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle k1/k2 ignored", editing, 0);

    // Timeout: one k1, then TO silent cycles abandon the edit.
    applyStimulus(1, 0, 0, 0);
    checkOutput("enter edit", editing, 1);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("still editing before timeout", editing, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("timeout editing", editing, 0);
    checkOutput("timeout cfg_freq", cfg_freq, 0);
    checkOutput("timeout no valid", validCycles, 0);

    // Basic edit and single-cycle commit with ready already high.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("commit valid", cfg_valid, 1);
    checkOutput("commit freq", cfg_freq, 3);
    checkOutput("commit rate", cfg_rate, 2);
    checkOutput("commit en", cfg_en, 1);
    v0 = validCycles;
    applyStimulus(0, 0, 0, 1);
    checkOutput("handshake done valid", cfg_valid, 0);
    checkOutput("single valid cycle", validCycles - v0, 1);

    // Key priority and cancelling keys, then a stalled handshake.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("k0 priority field", edit_field, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    v0 = validCycles;
    applyStimulus(1, 0, 0, 0);
    checkOutput("stall commit freq", cfg_freq, 3);
    checkOutput("stall commit en", cfg_en, 1);
    for (int i = 0; i < 7; i++) applyStimulus(0, (i % 2) == 0, 0, 0);
    checkOutput("stall valid held", cfg_valid, 1);
    checkOutput("stall rate held", cfg_rate, 2);
    applyStimulus(0, 1, 0, 1);
    checkOutput("stall valid dropped", cfg_valid, 0);
    checkOutput("stall valid cycles", validCycles - v0, 8);
    checkOutput("stall freq kept", cfg_freq, 3);

    // Asynchronous reset in the middle of a pending transfer.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pre-reset valid", cfg_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset valid", cfg_valid, 0);
    checkOutput("async reset freq", cfg_freq, 0);
    checkOutput("async reset rate", cfg_rate, 0);
    checkOutput("async reset en", cfg_en, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Wrap-around on freq and saturation on rate from cleared values.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("wrap freq", cfg_freq, 15);
    checkOutput("saturate rate", cfg_rate, 5);
    checkOutput("wrap en", cfg_en, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap handshake valid", cfg_valid, 0);

    applyStimulus(0, 0, 0, 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
